fifo_lane_reader: RTL
=====================

Name: fifo_lane_reader

Overview:
Read-side consumer for the team's FIFO output interface (data_out / data_out_valid / data_out_ack). It pops one DATA_WIDTH word at a time from the FIFO and serialises it into DATA_WIDTH/LANE_WIDTH narrower lanes on a valid/ready stream. It flags the last lane of each word and counts words consumed. It sits in the FIFO's output clock domain, between the FIFO and a narrow downstream datapath.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be an integer multiple of LANE_WIDTH, otherwise an elaboration error.
LANE_WIDTH, 8, output lane width; RATIO = DATA_WIDTH/LANE_WIDTH, RATIO >= 1.
LSB_FIRST, 1, 1: lane 0 = bits [LANE_WIDTH-1:0] is emitted first; 0: most-significant lane is emitted first.
COUNT_WIDTH, 16, width of words_read.

Ports:
clock_out  input  1  single clock for the whole block.
rst_out_n  input  1  asynchronous, active-low reset.
data_out  input  DATA_WIDTH  FIFO head word; stable while data_out_valid=1 and no ack has been seen.
data_out_valid  input  1  FIFO has a head word.
data_out_ack  output  1  registered one-cycle pop pulse to the FIFO.
lane_data  output  LANE_WIDTH  current lane.
lane_valid  output  1  lane_data is valid.
lane_last  output  1  lane_data is the final lane of its word.
lane_ready  input  1  downstream accepts; a transfer occurs on a clock edge where lane_valid & lane_ready.
words_read  output  COUNT_WIDTH  number of words popped since reset; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Clock and reset: one clock, clock_out; reset rst_out_n is asynchronous, active-low. While rst_out_n=0, all of the following are 0: data_out_ack, lane_data, lane_valid, lane_last, words_read, lane index, and the holding register. State is LOAD.
- State LOAD (holding register empty):
  - At an edge where data_out_valid=1 and data_out_ack=0: capture data_out into the holding register; data_out_ack<=1; words_read<=words_read+1.
  - On the same edge: lane_valid<=1, lane_data<=first lane, lane_last<=(RATIO==1), index<=0. Go to DRAIN.
  - At an edge where data_out_ack=1: no capture. The FIFO has not yet updated its head, so the stale word must not be re-read.
- data_out_ack is high for exactly one cycle per popped word, and never for two consecutive cycles.
- State DRAIN:
  - lane_data, lane_valid and lane_last are held while lane_ready=0.
  - On a transfer of a non-last lane: index+1; lane_data<=next lane in LSB_FIRST order; lane_last<=(index+1==RATIO-1).
  - On a transfer of the last lane: lane_valid<=0, lane_last<=0. Go to LOAD.
  - data_out_valid is ignored in DRAIN.
- Throughput: RATIO lanes per RATIO+1 cycles at best, plus one cycle if the ack gap applies (RATIO=1 gives 1 word per 2 cycles).
- FIFO empty: stay in LOAD; lane_valid=0; no ack.
- data_out_valid deasserting while in DRAIN: no effect; the held word drains completely.
- words_read wrap: 0xFFFF+1 -> 0x0000, with no flag.
- Reset mid-word: the partially drained word is discarded. data_out_ack drops immediately (asynchronously). After release, the next capture requires data_out_valid=1.
- lane_data is not guaranteed cleared between words; only reset clears it.

Decomposition:
- Shared package fifo_pkg: state encodings LOAD=1'b0, DRAIN=1'b1; default DATA_WIDTH=32 used by fifo and this block.
- RATIO and the index width $clog2(RATIO) (minimum 1) are local derived parameters.
- No sub-module: a single FSM + shift/index datapath in one module.

Test Plan:
- Reset, then FIFO presents 0x44332211 with lane_ready=1, LSB_FIRST=1 -> one ack pulse; lanes 0x11, 0x22, 0x33, 0x44 on consecutive cycles; lane_last only on 0x44; words_read=1.
- LSB_FIRST=0, same word -> lanes 0x44, 0x33, 0x22, 0x11.
- Back-to-back words 0xAABBCCDD then 0x01020304 with valid held high -> exactly 2 acks, never adjacent; 8 lanes in order; no duplicated word.
- lane_ready toggled 1,0,0,1,... mid-word -> lane_data/lane_last frozen while ready=0; no lane lost or repeated.
- rst_out_n pulsed low after 2 of 4 lanes -> all outputs 0 immediately; after release with valid=1 (0xCAFEF00D), lanes restart at 0x0D; words_read=1.
- COUNT_WIDTH=4, pop 17 words -> words_read reads 1 after wrapping.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and its read-side consumers.
// Holds the lane reader state encoding and the default FIFO word width.
package fifo_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } lane_state_e;

  localparam int FIFO_DATA_WIDTH = 32;

endpackage

// File: rtl/fifo_lane_reader.sv
// Pops words from the FIFO output interface and serialises each one into
// RATIO narrow lanes on a valid/ready stream, counting words consumed.
module fifo_lane_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int LANE_WIDTH  = 8,
  parameter int LSB_FIRST   = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_out,
  input  logic                   rst_out_n,
  input  logic [DATA_WIDTH-1:0]  data_out,
  input  logic                   data_out_valid,
  output logic                   data_out_ack,
  output logic [LANE_WIDTH-1:0]  lane_data,
  output logic                   lane_valid,
  output logic                   lane_last,
  input  logic                   lane_ready,
  output logic [COUNT_WIDTH-1:0] words_read
);

  localparam int RATIO = DATA_WIDTH / LANE_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((DATA_WIDTH % LANE_WIDTH) != 0 || RATIO < 1) begin : g_bad_ratio
    $error("fifo_lane_reader: DATA_WIDTH must be a positive multiple of LANE_WIDTH");
  end

  // Lane k in emission order, honouring LSB_FIRST.
  function automatic logic [LANE_WIDTH-1:0] lane_sel(input logic [DATA_WIDTH-1:0] word,
                                                      input int k);
    int                    pos;
    logic [DATA_WIDTH-1:0] shifted;
    pos     = (LSB_FIRST != 0) ? k : (RATIO - 1 - k);
    shifted = word >> (pos * LANE_WIDTH);
    return shifted[LANE_WIDTH-1:0];
  endfunction

  lane_state_e            state_q, state_d;
  logic                   capture, xfer;
  logic [DATA_WIDTH-1:0]  hold_p0;
  logic [IDX_W-1:0]       idx_p0, idx_next;
  logic                   ack_p0;
  logic [LANE_WIDTH-1:0]  lane_data_p0;
  logic                   lane_vld_p0;
  logic                   lane_last_p0;
  logic [COUNT_WIDTH-1:0] words_p0;

  assign idx_next = idx_p0 + IDX_W'(1);

  always_ff @(posedge clock_out or negedge rst_out_n) begin
    if (!rst_out_n) state_q <= LOAD;
    else            state_q <= state_d;
  end

  // A pending ack blocks capture: the FIFO head has not advanced yet.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      LOAD: begin
        if (data_out_valid && !ack_p0) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (lane_vld_p0 && lane_ready) begin
          xfer = 1'b1;
          if (lane_last_p0) state_d = LOAD;
        end
      end
    endcase
  end

  // Stage p0: holding register, lane output register and word counter.
  always_ff @(posedge clock_out or negedge rst_out_n) begin
    if (!rst_out_n) begin
      hold_p0      <= '0;
      idx_p0       <= '0;
      ack_p0       <= 1'b0;
      lane_data_p0 <= '0;
      lane_vld_p0  <= 1'b0;
      lane_last_p0 <= 1'b0;
      words_p0     <= '0;
    end else begin
      ack_p0 <= capture;
      if (capture) begin
        hold_p0      <= data_out;
        words_p0     <= words_p0 + COUNT_WIDTH'(1);
        idx_p0       <= '0;
        lane_vld_p0  <= 1'b1;
        lane_data_p0 <= lane_sel(data_out, 0);
        lane_last_p0 <= (RATIO == 1);
      end else if (xfer) begin
        if (lane_last_p0) begin
          lane_vld_p0  <= 1'b0;
          lane_last_p0 <= 1'b0;
        end else begin
          idx_p0       <= idx_next;
          lane_data_p0 <= lane_sel(hold_p0, int'(idx_next));
          lane_last_p0 <= (int'(idx_next) == RATIO - 1);
        end
      end
    end
  end

  assign data_out_ack = ack_p0;
  assign lane_data    = lane_data_p0;
  assign lane_valid   = lane_vld_p0;
  assign lane_last    = lane_last_p0;
  assign words_read   = words_p0;

endmodule
